menu_nav: RTL and testbench
===========================

# menu_nav

Parametrised menu navigator for the ATM front panel. It selects one of `NUM_ITEMS` instruction entries using up/down buttons with wrap-around, and scrolls the selected entry's text through an 8-character display window. It hands the confirmed choice to the ATM state machine over a valid/ready handshake. It sits between the debounce stage and the instruction seven-segment display driver. It replaces fixed four-entry menu muxing with a generic, reset-clean controller.

## Interface
- `NUM_ITEMS`, 4, number of menu entries (≥2)
- `CHAR_W`, 5, bits per character code
- `TEXT_LEN`, 16, characters per entry text (≥ `WIN`)
- `WIN`, 8, characters shown at once
- `SCROLL_DIV`, 100_000_000, clk cycles per scroll step (≥2)
- localparams: `IDX_W = $clog2(NUM_ITEMS)`, `POS_W = $clog2(TEXT_LEN)`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  menu active (ATM state machine is in menu state)
- `btn_up`  in  1  debounced level; a rising edge moves the index down
- `btn_down`  in  1  debounced level; a rising edge moves the index up
- `btn_ok`  in  1  debounced level; a rising edge confirms the selection
- `text_in`  in  `NUM_ITEMS*TEXT_LEN*CHAR_W`  entry texts; char k of item j at `[(j*TEXT_LEN+k)*CHAR_W +: CHAR_W]`
- `sel_ready`  in  1  downstream accepts the selection
- `sel_idx`  out  `IDX_W`  current highlighted entry
- `sel_valid`  out  1  confirmed selection pending
- `scroll_pos`  out  `POS_W`  first character index shown
- `disp_chars`  out  `WIN*CHAR_W`  window; display char i at `[i*CHAR_W +: CHAR_W]`

## Operation
- Edge detect per button: `press = btn & ~btn_prev`. During `rst`, `btn_prev` loads the current button levels, so a button held through reset release produces no press. Edge detection runs in every state, so a button held across a state change produces no press.
- FSM states:
  - IDLE: entered when `en`=0. No navigation. `tick` and `scroll_pos` held at 0.
  - BROWSE: entered from IDLE when `en`=1. On entry, `scroll_pos` and `tick` are cleared and `sel_idx` is retained.
  - CONFIRM: entered from BROWSE on an ok press. `sel_valid`=1, all buttons ignored, scrolling continues. Returns to BROWSE when `sel_valid & sel_ready`.
- `en`=0 in any state → IDLE on the next edge. `sel_valid` clears and any pending selection is dropped.
- Navigation in BROWSE, with priority ok > up/down:
  - up press: `sel_idx` = 0 → `NUM_ITEMS-1`, else `sel_idx-1`.
  - down press: `sel_idx` = `NUM_ITEMS-1` → 0, else `sel_idx+1`.
  - up and down pressed in the same cycle: ignored.
  - ok pressed together with up/down: confirm the current `sel_idx`; navigation is ignored.
- Any `sel_idx` change clears `scroll_pos` and `tick`.
- Scroll in BROWSE/CONFIRM: `tick` counts 0..`SCROLL_DIV-1`. At terminal count, `tick`←0 and `scroll_pos`←(`scroll_pos`+1) mod `TEXT_LEN`. `TEXT_LEN` need not be a power of 2, so wrap is an explicit compare.
- Window: display char i = text of `sel_idx` at (`scroll_pos`+i) mod `TEXT_LEN`. This is computed by explicit compare/subtract, not by bit truncation.
- `sel_idx` is stable while `sel_valid`=1.

## Timing
- Reset values: `sel_idx`=0, `sel_valid`=0, `scroll_pos`=0, `disp_chars`=0, `tick`=0, state IDLE.
- Press on edge k (btn high, `btn_prev` low) → `sel_idx`/`scroll_pos` updated at edge k.
- `disp_chars` is registered. It reflects `sel_idx`/`scroll_pos`/`text_in` one edge later (latency 1).
- Ok press at edge k → `sel_valid`=1 after edge k. Handshake completes at the first edge with `sel_valid & sel_ready`, and `sel_valid`=0 after that edge. `sel_ready` may be high in advance, giving a one-cycle pulse.
- `rst` overrides everything in the same edge, including mid-handshake and mid-scroll.
- Scroll step occurs every `SCROLL_DIV` cycles after entry or after an index change.

## Test plan
- **Reset / held button:** assert `rst` with `btn_down`=1, release, hold 10 cycles. Require `sel_idx`=0, `sel_valid`=0, `disp_chars` = item0 chars 0..7 one cycle after state BROWSE.
- **Wrap:** `en`=1, one up press gives `sel_idx`=3, a second gives 2. From 3, a down press gives 0. Each press clears `scroll_pos` to 0.
- **Scroll:** `SCROLL_DIV`=4, `TEXT_LEN`=10. After 40 cycles `scroll_pos` has stepped 0→9→0. At `scroll_pos`=7, window chars are item text 7,8,9,0,1,2,3,4.
- **Handshake:** `sel_idx`=2, ok press with `sel_ready`=0 for 5 cycles. Require `sel_valid` held, `sel_idx`=2, up presses ignored. Raise `sel_ready` → `sel_valid`=0 next edge, state BROWSE.
- **Simultaneous events:** up and down pressed in the same cycle → no change. Ok together with down → `sel_valid`=1 with the old `sel_idx`.
- **Abort:** drop `en` during CONFIRM → `sel_valid`=0 next edge. Re-raise `en` → BROWSE, `sel_idx` retained, `scroll_pos`=0.

Source files
------------

// File: rtl/menu_nav_if.sv
// Menu navigator bus: button levels, entry texts and the selection handshake
// toward the ATM state machine, plus the scrolled display window.
interface menu_nav_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CHAR_W    = 5,
    parameter int TEXT_LEN  = 16,
    parameter int WIN       = 8
);
    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam int POS_W = $clog2(TEXT_LEN);

    logic                               en;
    logic                               btn_up;
    logic                               btn_down;
    logic                               btn_ok;
    logic [NUM_ITEMS*TEXT_LEN*CHAR_W-1:0] text_in;
    logic                               sel_ready;
    logic [IDX_W-1:0]                   sel_idx;
    logic                               sel_valid;
    logic [POS_W-1:0]                   scroll_pos;
    logic [WIN*CHAR_W-1:0]              disp_chars;

    modport master (
        output en, btn_up, btn_down, btn_ok, text_in, sel_ready,
        input  sel_idx, sel_valid, scroll_pos, disp_chars
    );

    modport slave (
        input  en, btn_up, btn_down, btn_ok, text_in, sel_ready,
        output sel_idx, sel_valid, scroll_pos, disp_chars
    );
endinterface

// File: rtl/menu_nav.sv
// Menu navigator: wrap-around entry selection from button edges, timed text
// scrolling through a WIN-character window, and a valid/ready hand-off of the
// confirmed entry.
module menu_nav #(
    parameter int NUM_ITEMS  = 4,
    parameter int CHAR_W     = 5,
    parameter int TEXT_LEN   = 16,
    parameter int WIN        = 8,
    parameter int SCROLL_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    menu_nav_if.slave   bus
);
    localparam int IDX_W  = $clog2(NUM_ITEMS);
    localparam int POS_W  = $clog2(TEXT_LEN);
    localparam int TICK_W = $clog2(SCROLL_DIV);

    typedef enum logic [1:0] {IDLE, BROWSE, CONFIRM} state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [POS_W-1:0]    pos_q, pos_n;
    logic [TICK_W-1:0]   tick_q, tick_n;
    logic                up_prev, down_prev, ok_prev;
    logic                up_press, down_press, ok_press;
    logic                tick_tc;
    logic [POS_W-1:0]    pos_step;
    logic [WIN*CHAR_W-1:0] disp_q, disp_n;

    // Previous button levels; loading them during reset too means a button
    // held through reset release never looks like a fresh press.
    always_ff @(posedge clk) begin
        up_prev   <= bus.btn_up;
        down_prev <= bus.btn_down;
        ok_prev   <= bus.btn_ok;
    end

    assign up_press   = bus.btn_up   & ~up_prev;
    assign down_press = bus.btn_down & ~down_prev;
    assign ok_press   = bus.btn_ok   & ~ok_prev;

    // Scroll step values; TEXT_LEN may not be a power of two, so wrap by compare.
    assign tick_tc  = (tick_q == TICK_W'(SCROLL_DIV - 1));
    assign pos_step = (pos_q == POS_W'(TEXT_LEN - 1)) ? '0 : pos_q + POS_W'(1);

    // Next state, index, scroll position and tick counter.
    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        pos_n   = pos_q;
        tick_n  = tick_q;
        if (!bus.en) begin
            state_n = IDLE;
            pos_n   = '0;
            tick_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = BROWSE;
                    pos_n   = '0;
                    tick_n  = '0;
                end
                BROWSE, CONFIRM: begin
                    if (tick_tc) begin
                        tick_n = '0;
                        pos_n  = pos_step;
                    end else begin
                        tick_n = tick_q + TICK_W'(1);
                    end
                    if (state == CONFIRM) begin
                        // Buttons are ignored here; only the handshake moves us on.
                        if (bus.sel_ready) state_n = BROWSE;
                    end else if (ok_press) begin
                        state_n = CONFIRM;
                    end else if (up_press && !down_press) begin
                        idx_n  = (idx_q == '0) ? IDX_W'(NUM_ITEMS - 1) : idx_q - IDX_W'(1);
                        pos_n  = '0;
                        tick_n = '0;
                    end else if (down_press && !up_press) begin
                        idx_n  = (idx_q == IDX_W'(NUM_ITEMS - 1)) ? '0 : idx_q + IDX_W'(1);
                        pos_n  = '0;
                        tick_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx_q  <= '0;
            pos_q  <= '0;
            tick_q <= '0;
        end else begin
            state  <= state_n;
            idx_q  <= idx_n;
            pos_q  <= pos_n;
            tick_q <= tick_n;
        end
    end

    // Unpack entry texts into [item][char] for indexed lookup.
    logic [CHAR_W-1:0] chars [NUM_ITEMS][TEXT_LEN];

    for (genvar j = 0; j < NUM_ITEMS; j++) begin : g_item
        for (genvar k = 0; k < TEXT_LEN; k++) begin : g_char
            assign chars[j][k] = bus.text_in[(j*TEXT_LEN+k)*CHAR_W +: CHAR_W];
        end
    end

    // Window lane i shows char (scroll_pos+i) mod TEXT_LEN; the sum is below
    // 2*TEXT_LEN, so a single conditional subtract performs the wrap.
    for (genvar i = 0; i < WIN; i++) begin : g_win
        logic [POS_W:0]   sum;
        logic [POS_W-1:0] cpos;
        assign sum  = {1'b0, pos_q} + (POS_W+1)'(i);
        assign cpos = (sum >= (POS_W+1)'(TEXT_LEN)) ? POS_W'(sum - (POS_W+1)'(TEXT_LEN))
                                                    : sum[POS_W-1:0];
        assign disp_n[i*CHAR_W +: CHAR_W] = chars[idx_q][cpos];
    end

    // Registered display window, one edge behind index/position/text.
    always_ff @(posedge clk) begin
        if (rst) disp_q <= '0;
        else     disp_q <= disp_n;
    end

    assign bus.sel_idx    = idx_q;
    assign bus.sel_valid  = (state == CONFIRM);
    assign bus.scroll_pos = pos_q;
    assign bus.disp_chars = disp_q;
endmodule

// File: tb/tb_menu_nav.sv
// Bench for menu_nav: hand-written vector table, explicit scroll/window
// sequence, then random stimulus against a cycle-count reference model.
module tb_menu_nav;
    localparam int NI  = 4;
    localparam int CW  = 5;
    localparam int TL  = 10;
    localparam int W   = 8;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    menu_nav_if #(.NUM_ITEMS(NI), .CHAR_W(CW), .TEXT_LEN(TL), .WIN(W)) bus ();

    menu_nav #(.NUM_ITEMS(NI), .CHAR_W(CW), .TEXT_LEN(TL), .WIN(W), .SCROLL_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [CW-1:0] txt [NI][TL];

    // Reference model: mode 0 idle, 1 browse, 2 confirm; el counts edges since
    // entry or last index change, so scroll position is (el/DIV) mod TL.
    int            m_mode, m_idx, m_el;
    logic          m_pu, m_pd, m_po;
    logic [W*CW-1:0] m_disp;

    typedef struct {
        int rst, en, up, dn, ok, rdy;
        int e_idx, e_vld, e_pos;
    } vec_t;
    vec_t vt [23];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W*CW-1:0] window(input int idx, input int pos);
        logic [W*CW-1:0] r;
        for (int i = 0; i < W; i++) r[i*CW +: CW] = txt[idx][(pos + i) % TL];
        return r;
    endfunction

    task automatic pack_text();
        logic [NI*TL*CW-1:0] t;
        for (int j = 0; j < NI; j++)
            for (int k = 0; k < TL; k++)
                t[(j*TL+k)*CW +: CW] = txt[j][k];
        bus.text_in = t;
    endtask

    // Advance model with the applied inputs, clock once, compare all outputs.
    task automatic cycle();
        logic pu, pd, po;
        pu = bus.btn_up & ~m_pu;
        pd = bus.btn_down & ~m_pd;
        po = bus.btn_ok & ~m_po;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_el = 0; m_disp = '0;
        end else begin
            m_disp = window(m_idx, (m_el / DIV) % TL);
            if (!bus.en) begin
                m_mode = 0; m_el = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_el = 0;
            end else if (m_mode == 1) begin
                m_el++;
                if (po) m_mode = 2;
                else if (pu && !pd) begin m_idx = (m_idx + NI - 1) % NI; m_el = 0; end
                else if (pd && !pu) begin m_idx = (m_idx + 1) % NI; m_el = 0; end
            end else begin
                m_el++;
                if (bus.sel_ready) m_mode = 1;
            end
        end
        m_pu = bus.btn_up; m_pd = bus.btn_down; m_po = bus.btn_ok;
        @(posedge clk);
        #1;
        check("model sel_idx",    64'(bus.sel_idx),    64'(m_idx));
        check("model sel_valid",  64'(bus.sel_valid),  64'(m_mode == 2));
        check("model scroll_pos", 64'(bus.scroll_pos), 64'((m_el / DIV) % TL));
        check("model disp_chars", 64'(bus.disp_chars), 64'(m_disp));
    endtask

    task automatic set_in(input int r, input int e, input int u, input int d, input int o, input int y);
        rst = (r != 0);
        bus.en = (e != 0);
        bus.btn_up = (u != 0);
        bus.btn_down = (d != 0);
        bus.btn_ok = (o != 0);
        bus.sel_ready = (y != 0);
    endtask

    initial begin
        logic [W*CW-1:0] exp_w;
        int pre_pos;

        //          rst en up dn ok rdy  idx vld pos
        vt[0]  = '{1, 1, 0, 1, 0, 0,   0, 0, 0};  // reset with down held
        vt[1]  = '{0, 1, 0, 1, 0, 0,   0, 0, 0};  // held button: no press
        vt[2]  = '{0, 1, 0, 1, 0, 0,   0, 0, 0};
        vt[3]  = '{0, 1, 0, 0, 0, 0,   0, 0, 0};
        vt[4]  = '{0, 1, 1, 0, 0, 0,   3, 0, 0};  // up wraps 0 -> 3
        vt[5]  = '{0, 1, 0, 0, 0, 0,   3, 0, 0};
        vt[6]  = '{0, 1, 1, 0, 0, 0,   2, 0, 0};
        vt[7]  = '{0, 1, 0, 0, 0, 0,   2, 0, 0};
        vt[8]  = '{0, 1, 0, 1, 0, 0,   3, 0, 0};
        vt[9]  = '{0, 1, 0, 0, 0, 0,   3, 0, 0};
        vt[10] = '{0, 1, 0, 1, 0, 0,   0, 0, 0};  // down wraps 3 -> 0
        vt[11] = '{0, 1, 0, 0, 0, 0,   0, 0, 0};
        vt[12] = '{0, 1, 1, 1, 0, 0,   0, 0, 0};  // up+down together ignored
        vt[13] = '{0, 1, 0, 0, 0, 0,   0, 0, 0};
        vt[14] = '{0, 1, 0, 0, 0, 0,   0, 0, 1};  // fourth edge: scroll step
        vt[15] = '{0, 1, 0, 1, 1, 0,   0, 1, 1};  // ok+down: confirm old index
        vt[16] = '{0, 1, 0, 0, 0, 0,   0, 1, 1};
        vt[17] = '{0, 1, 1, 0, 0, 0,   0, 1, 1};  // up ignored in confirm
        vt[18] = '{0, 1, 0, 0, 0, 1,   0, 0, 2};  // handshake completes
        vt[19] = '{0, 1, 0, 0, 0, 1,   0, 0, 2};
        vt[20] = '{0, 1, 0, 0, 1, 0,   0, 1, 2};
        vt[21] = '{0, 0, 0, 0, 0, 0,   0, 0, 0};  // abort: en drop
        vt[22] = '{0, 1, 0, 0, 0, 0,   0, 0, 0};  // re-enter browse

        for (int j = 0; j < NI; j++)
            for (int k = 0; k < TL; k++)
                txt[j][k] = CW'($urandom);
        pack_text();
        m_pu = 1'b0; m_pd = 1'b0; m_po = 1'b0;
        set_in(1, 0, 0, 0, 0, 0);
        cycle();

        // Directed vector table.
        for (int r = 0; r < 23; r++) begin
            set_in(vt[r].rst, vt[r].en, vt[r].up, vt[r].dn, vt[r].ok, vt[r].rdy);
            cycle();
            check($sformatf("row%0d sel_idx", r),    64'(bus.sel_idx),    64'(vt[r].e_idx));
            check($sformatf("row%0d sel_valid", r),  64'(bus.sel_valid),  64'(vt[r].e_vld));
            check($sformatf("row%0d scroll_pos", r), 64'(bus.scroll_pos), 64'(vt[r].e_pos));
            if (r == 0) check("reset disp_chars", 64'(bus.disp_chars), 64'(0));
            if (r == 2) begin
                for (int i = 0; i < W; i++) exp_w[i*CW +: CW] = txt[0][i];
                check("item0 window after entry", 64'(bus.disp_chars), 64'(exp_w));
            end
        end

        // Scroll through a full text length and back to 0 on item 0.
        for (int c = 1; c <= 40; c++) begin
            pre_pos = bus.scroll_pos;
            set_in(0, 1, 0, 0, 0, 0);
            cycle();
            check($sformatf("scroll c%0d", c), 64'(bus.scroll_pos), 64'((c / DIV) % TL));
            if (pre_pos == 7) begin
                for (int i = 0; i < W; i++) exp_w[i*CW +: CW] = txt[0][(7 + i) % TL];
                check("window at pos 7", 64'(bus.disp_chars), 64'(exp_w));
            end
        end

        // Mid-confirm reset clears everything.
        set_in(0, 1, 0, 1, 0, 0); cycle();
        set_in(0, 1, 0, 0, 1, 0); cycle();
        check("confirm before reset", 64'(bus.sel_valid), 64'(1));
        set_in(1, 1, 0, 0, 1, 0); cycle();
        check("reset mid-confirm valid", 64'(bus.sel_valid), 64'(0));
        check("reset mid-confirm idx",   64'(bus.sel_idx),   64'(0));

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199) == 0);
            bus.en = ($urandom_range(39) != 0);
            if ($urandom_range(3) == 0) bus.btn_up   = ~bus.btn_up;
            if ($urandom_range(3) == 0) bus.btn_down = ~bus.btn_down;
            if ($urandom_range(5) == 0) bus.btn_ok   = ~bus.btn_ok;
            bus.sel_ready = ($urandom_range(2) == 0);
            if ($urandom_range(99) == 0) begin
                for (int j = 0; j < NI; j++)
                    for (int k = 0; k < TL; k++)
                        txt[j][k] = CW'($urandom);
                pack_text();
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
